contour_bin_stats: RTL and testbench

- Reader side of the contour-labelling path: scans the edge/label BRAM after contour tracing has written 3-bit bin labels (0 = unlabelled, 1..7 = bin index).
- For each bin 1..7 it accumulates pixel count and bounding box (min/max x, min/max y).
- Results are exposed through a registered bin-select readback port for downstream overlay and shape-matching logic.
- Drives the BRAM read port only; never writes.

---
 rtl/contour_bin_stats_if.sv | 25 ++
 rtl/contour_bin_stats.sv | 125 ++++++++++++
 tb/tb_contour_bin_stats.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/contour_bin_stats_if.sv
// contour_bin_stats_if: groups the scan handshake, label BRAM read port and bin readback port
//   master: start, label_data, bin_sel driven by the host/BRAM side
//   slave : busy, done, label_addr and bin_* results driven by contour_bin_stats
interface contour_bin_stats_if #(parameter int ADDR_W = 19);
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] label_addr;
   logic [2:0]        label_data;
   logic [2:0]        bin_sel;
   logic [18:0]       bin_count;
   logic [9:0]        bin_xmin;
   logic [9:0]        bin_xmax;
   logic [8:0]        bin_ymin;
   logic [8:0]        bin_ymax;
   logic              bin_present;
   modport master (
      output start, label_data, bin_sel,
      input  busy, done, label_addr, bin_count, bin_xmin, bin_xmax, bin_ymin, bin_ymax, bin_present
   );
   modport slave (
      input  start, label_data, bin_sel,
      output busy, done, label_addr, bin_count, bin_xmin, bin_xmax, bin_ymin, bin_ymax, bin_present
   );
endinterface

// File: rtl/contour_bin_stats.sv
// contour_bin_stats: scans the label BRAM and accumulates per-bin pixel count and bounding box
//   clk, reset : clock and synchronous active-high reset
//   bus (slave): start/busy/done handshake, label_addr/label_data BRAM read port,
//                bin_sel -> registered bin_count/bin_xmin/bin_xmax/bin_ymin/bin_ymax/bin_present
module contour_bin_stats #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int ADDR_W       = 19,
   parameter int READ_LATENCY = 2
) (
   input logic               clk,
   input logic               reset,
   contour_bin_stats_if.slave bus
);
   localparam int RL = READ_LATENCY;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [9:0] XL = 10'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [9:0]        x;
   logic [8:0]        y;
   logic [2:0]        dcnt;
   logic              busy_r, done_r;
   // coordinates of each in-flight read, aligned with label_data at stage RL-1
   logic [9:0]        px [RL];
   logic [8:0]        py [RL];
   logic              pv [RL];
   // entry 0 is never updated, so selecting bin 0 reads back as empty
   logic [18:0]       cnt [8];
   logic [9:0]        xmn [8], xmx [8];
   logic [8:0]        ymn [8], ymx [8];
   logic [18:0]       rc;
   logic [9:0]        rxn, rxx;
   logic [8:0]        ryn, ryx;
   logic              rp;
   logic [2:0]        l;
   logic              sel_ok;
   assign l = bus.label_data;
   assign sel_ok = cnt[bus.bin_sel] != '0;
   assign bus.label_addr  = addr;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.bin_count   = rc;
   assign bus.bin_xmin    = rxn;
   assign bus.bin_xmax    = rxx;
   assign bus.bin_ymin    = ryn;
   assign bus.bin_ymax    = ryx;
   assign bus.bin_present = rp;
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         addr   <= '0;
         x      <= '0;
         y      <= '0;
         dcnt   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         {rc, rxn, rxx, ryn, ryx, rp} <= '0;
         for (int i = 0; i < RL; i++) pv[i] <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
            xmn[i] <= '1;
            xmx[i] <= '0;
            ymn[i] <= '1;
            ymx[i] <= '0;
         end
      end else begin
         for (int i = RL - 1; i > 0; i--) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
            pv[i] <= pv[i-1];
         end
         px[0] <= x;
         py[0] <= y;
         pv[0] <= state == SCAN;
         if (pv[RL-1] && l != 3'd0) begin
            cnt[l] <= cnt[l] + 19'd1;
            xmn[l] <= px[RL-1] < xmn[l] ? px[RL-1] : xmn[l];
            xmx[l] <= px[RL-1] > xmx[l] ? px[RL-1] : xmx[l];
            ymn[l] <= py[RL-1] < ymn[l] ? py[RL-1] : ymn[l];
            ymx[l] <= py[RL-1] > ymx[l] ? py[RL-1] : ymx[l];
         end
         rc  <= sel_ok ? cnt[bus.bin_sel] : '0;
         rxn <= sel_ok ? xmn[bus.bin_sel] : '0;
         rxx <= sel_ok ? xmx[bus.bin_sel] : '0;
         ryn <= sel_ok ? ymn[bus.bin_sel] : '0;
         ryx <= sel_ok ? ymx[bus.bin_sel] : '0;
         rp  <= sel_ok;
         if ((state == IDLE || state == DONE) && bus.start) begin
            for (int i = 0; i < 8; i++) begin
               cnt[i] <= '0;
               xmn[i] <= '1;
               xmx[i] <= '0;
               ymn[i] <= '1;
               ymx[i] <= '0;
            end
            addr   <= '0;
            x      <= '0;
            y      <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b1;
            state  <= SCAN;
         end else if (state == SCAN) begin
            if (addr == LAST) begin
               dcnt  <= '0;
               state <= DRAIN;
            end else begin
               addr <= addr + 1'b1;
               x    <= x == XL ? 10'd0 : x + 10'd1;
               y    <= x == XL ? y + 9'd1 : y;
            end
         end else if (state == DRAIN) begin
            // one extra cycle past the final accumulate so done appears with stable stats
            if (dcnt == 3'(RL)) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
               state  <= DONE;
            end else begin
               dcnt <= dcnt + 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_contour_bin_stats.sv
// tb_contour_bin_stats: three 8x4 instances (read latency 1, 2, 4) scanning one shared label image
module tb_contour_bin_stats;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] bin_sel;
   logic [2:0] mem [32];
   logic       done_v [3], busy_v [3], pres_v [3];
   logic [4:0] addr_v [3];
   logic [18:0] cnt_v [3];
   logic [9:0] xmn_v [3], xmx_v [3];
   logic [8:0] ymn_v [3], ymx_v [3];
   int         rl [3] = '{1, 2, 4};
   int         tests = 0;
   int         fails = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int RL = g == 0 ? 1 : g == 1 ? 2 : 4;
      contour_bin_stats_if #(.ADDR_W(5)) bus ();
      logic [2:0] d [RL];
      contour_bin_stats #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5), .READ_LATENCY(RL)) dut (
         .clk(clk), .reset(reset), .bus(bus)
      );
      always @(posedge clk) begin
         d[0] <= mem[bus.label_addr];
         for (int i = 1; i < RL; i++) d[i] <= d[i-1];
      end
      assign bus.start      = start;
      assign bus.bin_sel    = bin_sel;
      assign bus.label_data = d[RL-1];
      assign done_v[g] = bus.done;
      assign busy_v[g] = bus.busy;
      assign pres_v[g] = bus.bin_present;
      assign addr_v[g] = bus.label_addr;
      assign cnt_v[g]  = bus.bin_count;
      assign xmn_v[g]  = bus.bin_xmin;
      assign xmx_v[g]  = bus.bin_xmax;
      assign ymn_v[g]  = bus.bin_ymin;
      assign ymx_v[g]  = bus.bin_ymax;
   end
   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s rl=%0d: got %0d expected %0d", tag, rl[i], obs, exp);
      end
   endtask
   task automatic run_scan(input int restart_at);
      int dt [3];
      bit bbad [3];
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("busy_after_start", i, 32'(busy_v[i]), 1);
         chk("done_after_start", i, 32'(done_v[i]), 0);
         dt[i] = 0;
         bbad[i] = 1'b0;
      end
      for (int k = 1; k <= 100 && !(dt[0] != 0 && dt[1] != 0 && dt[2] != 0); k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (k == restart_at) start = 1'b1;
         for (int i = 0; i < 3; i++)
            if (dt[i] == 0) begin
               if (done_v[i]) dt[i] = k;
               else if (!busy_v[i]) bbad[i] = 1'b1;
            end
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("done_latency", i, dt[i], 32 + rl[i] + 1);
         chk("busy_dropout", i, 32'(bbad[i]), 0);
         chk("busy_at_end", i, 32'(busy_v[i]), 0);
      end
   endtask
   task automatic check_bins();
      int c, xn, xx, yn, yx;
      for (int b = 0; b < 8; b++) begin
         c = 0; xn = 1023; xx = 0; yn = 511; yx = 0;
         for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
               if (b != 0 && mem[y*8+x] == 3'(b)) begin
                  c++;
                  if (x < xn) xn = x;
                  if (x > xx) xx = x;
                  if (y < yn) yn = y;
                  if (y > yx) yx = y;
               end
         if (c == 0) begin xn = 0; yn = 0; end
         bin_sel = 3'(b);
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("count bin%0d", b), i, 32'(cnt_v[i]), c);
            chk($sformatf("xmin bin%0d", b), i, 32'(xmn_v[i]), xn);
            chk($sformatf("xmax bin%0d", b), i, 32'(xmx_v[i]), xx);
            chk($sformatf("ymin bin%0d", b), i, 32'(ymn_v[i]), yn);
            chk($sformatf("ymax bin%0d", b), i, 32'(ymx_v[i]), yx);
            chk($sformatf("present bin%0d", b), i, 32'(pres_v[i]), 32'(c != 0));
         end
      end
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      bin_sel = 3'd3;
      for (int i = 0; i < 32; i++) mem[i] = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_busy", i, 32'(busy_v[i]), 0);
         chk("reset_done", i, 32'(done_v[i]), 0);
         chk("reset_addr", i, 32'(addr_v[i]), 0);
         chk("reset_count", i, 32'(cnt_v[i]), 0);
         chk("reset_xmin", i, 32'(xmn_v[i]), 0);
         chk("reset_present", i, 32'(pres_v[i]), 0);
      end
      reset = 1'b0;
      mem[10] = 3'd3;
      mem[13] = 3'd3;
      mem[28] = 3'd3;
      run_scan(0);
      check_bins();
      for (int i = 0; i < 32; i++) mem[i] = 3'd1;
      mem[0] = 3'd7;
      mem[31] = 3'd7;
      run_scan(0);
      check_bins();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 32; i++)
            mem[i] = r[0] ? 3'($urandom_range(0, 7)) : ($urandom_range(0, 2) == 0 ? 3'd0 : 3'($urandom_range(1, 4)));
         run_scan(r == 1 ? 10 : 0);
         check_bins();
      end
      for (int i = 0; i < 32; i++) mem[i] = 3'($urandom_range(1, 7));
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk("midscan_reset_busy", i, 32'(busy_v[i]), 0);
         chk("midscan_reset_done", i, 32'(done_v[i]), 0);
         chk("midscan_reset_addr", i, 32'(addr_v[i]), 0);
         chk("midscan_reset_count", i, 32'(cnt_v[i]), 0);
      end
      reset = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom_range(0, 1) == 0 ? 3'd0 : 3'($urandom_range(2, 6));
      run_scan(0);
      check_bins();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
